// File: rtl/uio_arb_pkg.sv
// Shared types and widths for the uio pad bus arbiter.
// The optional hold timeout is enabled with the UIO_ARB_TIMEOUT_EN macro in uio_bus_arbiter.
package uio_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int PIN_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uio_arb_rr.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie
// the requester that did not own the bus last wins.
module uio_arb_rr
  import uio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the uio pad bus between two requesters with a forced all-inputs turnaround gap.
// Define UIO_ARB_TIMEOUT_EN to let a waiting requester preempt an owner after TIMEOUT cycles.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic [PIN_W-1:0]   out0,
  input  logic [PIN_W-1:0]   oe0,
  input  logic [PIN_W-1:0]   out1,
  input  logic [PIN_W-1:0]   oe1,
  output logic [PIN_W-1:0]   uio_out,
  output logic [PIN_W-1:0]   uio_oe,
  input  logic [PIN_W-1:0]   uio_in,
  output logic [PIN_W-1:0]   uio_in_q,
  output logic               preempt
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [3:0]         turn_q;
  logic               last_q;
  logic [NUM_REQ-1:0] pick;
  logic               timeout_hit;

  uio_arb_rr u_rr (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only looked at in IDLE and by the current owner; TURN runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick[0]) begin
          state_d = OWN0;
        end else if (pick[1]) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req[0] || timeout_hit) begin
          state_d = TURN;
        end
      end
      OWN1: begin
        if (!req[1] || timeout_hit) begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant    = '0;
    grant[0] = (state_q == OWN0);
    grant[1] = (state_q == OWN1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_q <= '0;
    end else if (state_q != TURN) begin
      turn_q <= '0;
    end else begin
      turn_q <= turn_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && state_d == OWN0) begin
      last_q <= 1'b0;
    end else if (state_q == IDLE && state_d == OWN1) begin
      last_q <= 1'b1;
    end
  end

  // Enables only follow an owner that keeps the bus across this edge; uio_out holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uio_out  <= '0;
      uio_oe   <= '0;
      uio_in_q <= '0;
    end else begin
      uio_in_q <= uio_in;
      if (state_q == OWN0 && state_d == OWN0) begin
        uio_out <= out0;
        uio_oe  <= oe0;
      end else if (state_q == OWN1 && state_d == OWN1) begin
        uio_out <= out1;
        uio_oe  <= oe1;
      end else begin
        uio_oe  <= '0;
      end
    end
  end

`ifdef UIO_ARB_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  logic [TO_W-1:0] to_q;
  logic            waiting;
  logic            owning;

  always_comb begin
    owning      = (state_q == OWN0) || (state_q == OWN1);
    waiting     = (state_q == OWN0 && req[1]) || (state_q == OWN1 && req[0]);
    timeout_hit = owning && (to_q == TO_LAST);
  end

  // Counts only the cycles in which the other side is actually waiting; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
    end else if (!owning) begin
      to_q <= '0;
    end else if (waiting && to_q != TO_MAX) begin
      to_q <= to_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preempt <= 1'b0;
    end else begin
      preempt <= timeout_hit &&
                 ((state_q == OWN0 && req[0]) || (state_q == OWN1 && req[1]));
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: vector table, corner-case sequences
// and a randomized run against a cycle-level ownership model.
module tb_uio_bus_arbiter;

  localparam int TURN_CYCLES = 2;
  localparam int TIMEOUT     = 8;
`ifdef UIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] grant;
  logic [7:0] out0 = '0, oe0 = '0, out1 = '0, oe1 = '0, uio_in = '0;
  logic [7:0] uio_out, uio_oe, uio_in_q;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  uio_bus_arbiter #(
    .TURN_CYCLES (TURN_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .out0     (out0),
    .oe0      (oe0),
    .out1     (out1),
    .oe1      (oe1),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .uio_in   (uio_in),
    .uio_in_q (uio_in_q),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] out0, oe0, out1, oe1, uio_in;
    logic [1:0] exp_grant;
    logic [7:0] exp_out, exp_oe, exp_in_q;
  } vec_t;

  vec_t vecs[12];

  // Reference model: who owns the bus, how many dead cycles remain, who owned last
  int         m_owner, m_gap, m_last, m_wait;
  logic [7:0] m_out, m_oe, m_inq;
  logic       m_pre;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] o0, input logic [7:0] e0,
                               input logic [7:0] o1, input logic [7:0] e1, input logic [7:0] ui);
    req    = r;
    out0   = o0;
    oe0    = e0;
    out1   = o1;
    oe1    = e1;
    uio_in = ui;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_gap   = 0;
    m_last  = 1;
    m_wait  = 0;
    m_out   = '0;
    m_oe    = '0;
    m_inq   = '0;
    m_pre   = 1'b0;
  endtask

  task automatic modelStep();
    logic own_req, oth_req;
    m_inq = uio_in;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      own_req = req[m_owner];
      oth_req = req[1 - m_owner];
      if (!own_req || (TO_EN && m_wait == TIMEOUT - 1)) begin
        m_pre   = TO_EN && own_req;
        m_oe    = '0;
        m_owner = -1;
        m_gap   = TURN_CYCLES;
      end else begin
        m_out = (m_owner == 1) ? out1 : out0;
        m_oe  = (m_owner == 1) ? oe1 : oe0;
        if (oth_req && m_wait < TIMEOUT) m_wait++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != 2'b00) begin
      if (req == 2'b11) m_owner = 1 - m_last;
      else m_owner = req[0] ? 0 : 1;
      m_last = m_owner;
      m_wait = 0;
    end
  endtask

  function automatic logic [1:0] modelGrant();
    if (m_owner == 0) return 2'b01;
    if (m_owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    int g0, pre, dead;
    bit got1;
    logic [1:0] rnd_req;

    vecs[0]  = '{2'b01, 8'hA5, 8'h0F, 8'h77, 8'hFF, 8'h3C, 2'b01, 8'h00, 8'h00, 8'h3C};
    vecs[1]  = '{2'b01, 8'hA5, 8'h0F, 8'h77, 8'hFF, 8'h11, 2'b01, 8'hA5, 8'h0F, 8'h11};
    vecs[2]  = '{2'b11, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h22, 2'b01, 8'h5A, 8'hF0, 8'h22};
    vecs[3]  = '{2'b10, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h33, 2'b00, 8'h5A, 8'h00, 8'h33};
    vecs[4]  = '{2'b10, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h44, 2'b00, 8'h5A, 8'h00, 8'h44};
    vecs[5]  = '{2'b10, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h55, 2'b00, 8'h5A, 8'h00, 8'h55};
    vecs[6]  = '{2'b10, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h66, 2'b10, 8'h5A, 8'h00, 8'h66};
    vecs[7]  = '{2'b10, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h77, 2'b10, 8'h77, 8'hFF, 8'h77};
    vecs[8]  = '{2'b00, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h88, 2'b00, 8'h77, 8'h00, 8'h88};
    vecs[9]  = '{2'b01, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'h99, 2'b00, 8'h77, 8'h00, 8'h99};
    vecs[10] = '{2'b01, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'hAA, 2'b00, 8'h77, 8'h00, 8'hAA};
    vecs[11] = '{2'b01, 8'h5A, 8'hF0, 8'h77, 8'hFF, 8'hBB, 2'b01, 8'h77, 8'h00, 8'hBB};

    // Reset values
    doReset();
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset uio_oe", 32'(uio_oe), 32'h0);
    checkOutput("reset uio_out", 32'(uio_out), 32'h0);
    checkOutput("reset uio_in_q", 32'(uio_in_q), 32'h0);
    checkOutput("reset preempt", 32'(preempt), 32'h0);

    // Vector table: single grant, release, turnaround, requests ignored in TURN
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req, vecs[i].out0, vecs[i].oe0, vecs[i].out1, vecs[i].oe1, vecs[i].uio_in);
      tick();
      checkOutput($sformatf("tbl%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      checkOutput($sformatf("tbl%0d uio_out", i), 32'(uio_out), 32'(vecs[i].exp_out));
      checkOutput($sformatf("tbl%0d uio_oe", i), 32'(uio_oe), 32'(vecs[i].exp_oe));
      checkOutput($sformatf("tbl%0d uio_in_q", i), 32'(uio_in_q), 32'(vecs[i].exp_in_q));
      checkOutput($sformatf("tbl%0d preempt", i), 32'(preempt), 32'h0);
    end

    // Reset mid-ownership clears the enables without a clock edge
    doReset();
    applyStimulus(2'b01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("own0 uio_oe", 32'(uio_oe), 32'hFF);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst uio_oe", 32'(uio_oe), 32'h0);
    checkOutput("async rst grant", 32'(grant), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b11, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
    tick();
    checkOutput("post rst first grant", 32'(grant), 32'h1);

    // Release with the other side waiting
    doReset();
    applyStimulus(2'b11, 8'h12, 8'h34, 8'h3C, 8'hC3, 8'h00);
    tick();
    checkOutput("handoff own0", 32'(grant), 32'h1);
    tick();
    req = 2'b10;
    tick();
    checkOutput("handoff oe at k", 32'(uio_oe), 32'h0);
    checkOutput("handoff grant k", 32'(grant), 32'h0);
    tick();
    checkOutput("handoff grant k+1", 32'(grant), 32'h0);
    tick();
    checkOutput("handoff grant k+2", 32'(grant), 32'h0);
    tick();
    checkOutput("handoff grant k+3", 32'(grant), 32'h2);
    checkOutput("handoff oe k+3", 32'(uio_oe), 32'h0);
    tick();
    checkOutput("handoff oe k+4", 32'(uio_oe), 32'hC3);
    checkOutput("handoff out k+4", 32'(uio_out), 32'h3C);

    // Simultaneous requests: 0 first, then 1 after 0 releases briefly
    doReset();
    applyStimulus(2'b11, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00);
    tick();
    checkOutput("simul first", 32'(grant), 32'h1);
    req = 2'b10;
    tick();
    req = 2'b11;
    tick();
    tick();
    checkOutput("simul gap", 32'(grant), 32'h0);
    tick();
    checkOutput("simul second", 32'(grant), 32'h2);

    // Hold timeout with both requesters permanently high
    doReset();
    applyStimulus(2'b11, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00);
    tick();
    g0 = 0; pre = 0; dead = 0; got1 = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
    for (int i = 0; i < 40 && !got1; i++) begin
      if (grant == 2'b01) g0++;
      else if (grant == 2'b00) dead++;
      else got1 = 1'b1;
      if (preempt) pre++;
      if (!got1) tick();
    end
    checkOutput("timeout grant cycles", 32'(g0), 32'(TIMEOUT));
    checkOutput("timeout preempt width", 32'(pre), 32'h1);
    checkOutput("timeout dead cycles", 32'(dead), 32'(TURN_CYCLES + 1));
    checkOutput("timeout next grant", 32'(got1), 32'h1);
`else
    for (int i = 0; i < 1000; i++) begin
      if (grant == 2'b01) g0++;
      if (preempt) pre++;
      tick();
    end
    checkOutput("no timeout held", 32'(g0), 32'd1000);
    checkOutput("no timeout preempt", 32'(pre), 32'h0);
`endif

    // Randomized run against the reference model
    doReset();
    modelReset();
    rnd_req = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rnd_req[0] = ~rnd_req[0];
      if ($urandom_range(7) == 0) rnd_req[1] = ~rnd_req[1];
      applyStimulus(rnd_req, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput($sformatf("random cycle %0d {grant,out,oe,in_q,preempt}", i),
                  32'({grant, uio_out, uio_oe, uio_in_q, preempt}),
                  32'({modelGrant(), m_out, m_oe, m_inq, m_pre}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Shares the 8-bit bidirectional uio pad bus between two on-chip requesters, e.g. the QSPI memory controller and a debug/UART bridge, in the ECP5 build of tinyQV. The block sits between the requesters and the tri-state pad logic. It grants the bus round-robin and forces a turnaround gap with all output enables low between owners, so two drivers never overlap. An optional hold timeout can preempt an owner.

## Interface

- TURN_CYCLES, 2: cycles with uio_oe forced to 0 after every release; legal range is 1..15.
- TIMEOUT, 64: maximum number of ownership cycles while the other requester waits; used only with UIO_ARB_TIMEOUT_EN.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- req  in  2  level request; bit x is held high while requester x wants the bus.
- grant  out  2  one-hot or zero; bit x is high while requester x owns the bus.
- out0, oe0  in  8 each  requester 0 pin drive value and pin enables.
- out1, oe1  in  8 each  requester 1 pin drive value and pin enables.
- uio_out  out  8  registered drive value to the pads.
- uio_oe  out  8  registered output enables to the pads.
- uio_in  in  8  pad input.
- uio_in_q  out  8  uio_in registered once; goes to both requesters.
- preempt  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation

- States: IDLE, OWN0, OWN1, TURN.
- Reset values: state IDLE; grant 0; uio_out, uio_oe, uio_in_q 0; preempt 0; last-owner pointer 1, so requester 0 wins the first tie.
- IDLE:
  - One request high: go to OWNx for that requester.
  - Both high: go to the requester that is not the last owner.
  - Last-owner pointer updates on entry to OWNx.
- OWNx:
  - grant[x] = 1.
  - Each edge, uio_out <= outx and uio_oe <= oex.
  - When req[x] is sampled low: go to TURN, and at that same edge uio_oe <= 0 and grant <= 0.
- TURN:
  - uio_oe held at 0 and grant = 0 for TURN_CYCLES cycles.
  - Requests are ignored; req changes during TURN have no effect.
  - Then go to IDLE and arbitrate on the next edge.
- uio_out during IDLE and TURN holds its last value; only uio_oe is forced to 0.
- grant and the FSM state change at the same edge, so the pad enables never reflect a non-owner.
- Any rst assertion clears uio_oe immediately, whatever the state.

## Timing

- req[x] rises with the bus in IDLE and is sampled at edge k:
  - grant[x] is high after edge k.
  - uio_oe/uio_out carry oex/outx after edge k+1.
  - Latency: 2 edges from req to the pins.
- Release sampled at edge k: uio_oe is 0 after edge k; the next grant is high no earlier than after edge k+TURN_CYCLES+1.
- Back-to-back handoff with both requesters permanently high (TURN_CYCLES=2), per ownership period:
  - Before the forced release: under UIO_ARB_TIMEOUT_EN, TIMEOUT cycles of grant then 3 dead cycles.
  - Without the macro, no handoff happens until the owner drops req.
- uio_in_q = uio_in delayed by one edge, independent of state.
- Turn counter width: 4 bits.
- Timeout counter width: $clog2(TIMEOUT+1) bits; it saturates and never wraps.

## Configuration

- UIO_ARB_TIMEOUT_EN defined:
  - In OWNx, a counter increments each cycle while req of the other requester is high, and clears on entry to OWNx.
  - When it reaches TIMEOUT-1, the next edge behaves as a release: go to TURN, uio_oe <= 0, grant <= 0, preempt pulses for 1 cycle.
  - The preempted requester must deassert its req or wait; it re-arbitrates normally.
- Undefined: no counter, preempt tied to 0, and ownership lasts until req drops.

## Structure

- Package uio_arb_pkg: state enum (IDLE, OWN0, OWN1, TURN), NUM_REQ=2, PIN_W=8.
- One sub-module, uio_arb_rr: a 2-way round-robin picker with inputs req and last-owner, and a one-hot pick output.
- Counters and the pad registers are inline in uio_bus_arbiter.

## Test plan

- Reset mid-ownership:
  - Stimulus: assert rst while in OWN0 with oe0=8'hFF.
  - Required: uio_oe=0 without waiting for clk; grant=0; state IDLE. After release, req[0] gets the first grant.
- Single requester:
  - Stimulus: req[0] high at edge 0 with out0=8'hA5, oe0=8'h0F.
  - Required: grant=2'b01 after edge 0; uio_out=8'hA5, uio_oe=8'h0F after edge 1.
- Release and turnaround (TURN_CYCLES=2):
  - Stimulus: req[0] drops at edge 10 while req[1] is high.
  - Required: uio_oe=0 after edge 10; grant=0 through edge 12; grant=2'b10 after edge 13; oe1 visible on the pins after edge 14.
- Simultaneous requests:
  - Stimulus: both req bits rise together from reset.
  - Required: requester 0 is granted first. After it releases, with both still high, requester 1 is granted next.
- Timeout (macro defined, TIMEOUT=8):
  - Stimulus: req[0] held high forever; req[1] asserted.
  - Required: grant[0] revoked 8 cycles later, preempt high for exactly 1 cycle, then TURN, then grant=2'b10.
- Macro undefined, same stimulus as the timeout scenario:
  - Required: grant[0] held for 1000 cycles; preempt never asserts.
